// File: rtl/pc_pkg.sv
// Shared encodings for the piRISC next-PC sequencer.
//   pc_sel_e : operation selected by decode for the committing instruction
//   cause_e  : trap cause reported alongside epc
//   state_e  : sequencer control state
package pc_pkg;

  typedef enum logic [2:0] {
    PC_NORMAL = 3'b000,
    PC_BRANCH = 3'b001,
    PC_JAL    = 3'b010,
    PC_JALR   = 3'b011,
    PC_ECALL  = 3'b100,
    PC_MRET   = 3'b101,
    PC_HALT   = 3'b110,
    PC_RSVD   = 3'b111
  } pc_sel_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_MISALIGN = 2'd1,
    CAUSE_ECALL    = 2'd2,
    CAUSE_EXT      = 2'd3
  } cause_e;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC target mux with misalignment detection.
// Ports:
//   pc, imm, rs1, epc : current PC, sign-extended immediate, rs1 operand, saved EPC
//   comparator        : branch condition
//   pc_select         : operation (pc_pkg::pc_sel_e encoding)
//   target            : candidate next PC
//   misaligned        : target violates IALIGN on a checked control transfer
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int                DWIDTH      = 32,
  parameter logic [DWIDTH-1:0] TRAP_VECTOR = 32'h0000_0100,
  parameter int                IALIGN      = 4
) (
  input  logic [DWIDTH-1:0] pc,
  input  logic [DWIDTH-1:0] imm,
  input  logic [DWIDTH-1:0] rs1,
  input  logic [DWIDTH-1:0] epc,
  input  logic              comparator,
  input  logic [2:0]        pc_select,
  output logic [DWIDTH-1:0] target,
  output logic              misaligned
);

  localparam logic [DWIDTH-1:0] INCR       = DWIDTH'(4);
  localparam logic [DWIDTH-1:0] ALIGN_MASK = DWIDTH'(IALIGN - 1);

  // IALIGN is a power of two, so "mod IALIGN" reduces to the low bits.
  function automatic logic is_misaligned(input logic [DWIDTH-1:0] addr);
    return (addr & ALIGN_MASK) != '0;
  endfunction

  logic signed [DWIDTH-1:0] imm_s;
  logic        [DWIDTH-1:0] seq_tgt;
  logic        [DWIDTH-1:0] rel_tgt;
  logic        [DWIDTH-1:0] jalr_sum;
  logic                     check;

  assign imm_s    = $signed(imm);
  assign seq_tgt  = pc + INCR;
  assign rel_tgt  = $unsigned($signed(pc) + imm_s);
  assign jalr_sum = $unsigned($signed(rs1) + imm_s);

  always_comb begin
    target = seq_tgt;
    check  = 1'b0;
    case (pc_sel_e'(pc_select))
      PC_BRANCH: begin
        // A not-taken branch is a plain increment and is never checked.
        if (comparator) begin
          target = rel_tgt;
          check  = 1'b1;
        end
      end
      PC_JAL: begin
        target = rel_tgt;
        check  = 1'b1;
      end
      PC_JALR: begin
        // Bit 0 is cleared before the alignment check, so only IALIGN=4
        // can fault on an odd-by-two JALR target.
        target = {jalr_sum[DWIDTH-1:1], 1'b0};
        check  = 1'b1;
      end
      PC_ECALL: target = TRAP_VECTOR;
      PC_MRET: begin
        target = epc;
        check  = 1'b1;
      end
      default: target = seq_tgt;
    endcase
  end

  assign misaligned = check && is_misaligned(target);

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC sequencer for the piRISC core: owns the architectural PC, drives
// the fetch request, and handles trap entry/return and halt/resume.
// Ports:
//   clk, reset        : rising-edge clock, asynchronous active-high reset
//   pc_en, fetch_ready: a commit happens when both are high in S_RUN
//   pc_select         : operation of the committing instruction
//   immgen_in, rs1_in : immediate and rs1 operands for target computation
//   comparator        : branch condition
//   trap_req          : external trap request (taken only on a commit)
//   resume            : leave S_HALT
//   pc_value, pc_link : current PC / fetch address and PC+4 for rd
//   fetch_valid       : pc_value is a valid fetch request
//   epc, cause        : trap PC and cause (sticky until next trap/reset)
//   trap_pulse        : high the cycle after a trap commits
//   halted            : high in S_HALT
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                DWIDTH       = 32,
  parameter logic [DWIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [DWIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int                IALIGN       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_en,
  input  logic [2:0]        pc_select,
  input  logic [DWIDTH-1:0] immgen_in,
  input  logic [DWIDTH-1:0] rs1_in,
  input  logic              comparator,
  input  logic              trap_req,
  input  logic              resume,
  input  logic              fetch_ready,
  output logic [DWIDTH-1:0] pc_value,
  output logic [DWIDTH-1:0] pc_link,
  output logic              fetch_valid,
  output logic [DWIDTH-1:0] epc,
  output logic [1:0]        cause,
  output logic              trap_pulse,
  output logic              halted
);

  state_e            state_q, state_d;
  logic [DWIDTH-1:0] pc_q, pc_d;
  logic [DWIDTH-1:0] epc_q, epc_d;
  logic [1:0]        cause_q, cause_d;
  logic              pulse_q, pulse_d;
  logic [DWIDTH-1:0] target;
  logic              misaligned;
  logic              commit;

  pc_target_calc #(
    .DWIDTH      (DWIDTH),
    .TRAP_VECTOR (TRAP_VECTOR),
    .IALIGN      (IALIGN)
  ) u_target (
    .pc         (pc_q),
    .imm        (immgen_in),
    .rs1        (rs1_in),
    .epc        (epc_q),
    .comparator (comparator),
    .pc_select  (pc_select),
    .target     (target),
    .misaligned (misaligned)
  );

  assign commit = (state_q == S_RUN) && pc_en && fetch_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    pulse_d = 1'b0;
    case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        if (commit) begin
          // External request outranks a faulting target; epc names the
          // instruction that has not executed yet.
          if (trap_req) begin
            pc_d    = TRAP_VECTOR;
            epc_d   = pc_q;
            cause_d = CAUSE_EXT;
            pulse_d = 1'b1;
          end else if (misaligned) begin
            pc_d    = TRAP_VECTOR;
            epc_d   = pc_q;
            cause_d = CAUSE_MISALIGN;
            pulse_d = 1'b1;
          end else begin
            pc_d = target;
            if (pc_sel_e'(pc_select) == PC_ECALL) begin
              epc_d   = pc_q;
              cause_d = CAUSE_ECALL;
              pulse_d = 1'b1;
            end
            if (pc_sel_e'(pc_select) == PC_HALT) state_d = S_HALT;
          end
        end
      end
      S_HALT: begin
        if (resume) state_d = S_RUN;
      end
      default: state_d = S_BOOT;
    endcase
  end

  // Register stage: every output except pc_link comes straight from here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      cause_q <= CAUSE_NONE;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      pulse_q <= pulse_d;
    end
  end

  assign pc_value    = pc_q;
  assign pc_link     = pc_q + DWIDTH'(4);
  assign fetch_valid = (state_q == S_RUN);
  assign halted      = (state_q == S_HALT);
  assign epc         = epc_q;
  assign cause       = cause_q;
  assign trap_pulse  = pulse_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam logic [2:0] NORMAL = 3'b000;
  localparam logic [2:0] BRANCH = 3'b001;
  localparam logic [2:0] JAL    = 3'b010;
  localparam logic [2:0] JALR   = 3'b011;
  localparam logic [2:0] ECALL  = 3'b100;
  localparam logic [2:0] MRET   = 3'b101;
  localparam logic [2:0] HALT   = 3'b110;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_en, comparator, trap_req, resume, fetch_ready;
  logic [2:0]  pc_select;
  logic [31:0] immgen_in, rs1_in;

  logic [31:0] pc_value, pc_link, epc;
  logic [1:0]  cause;
  logic        fetch_valid, trap_pulse, halted;

  logic [31:0] pc_value2, pc_link2, epc2;
  logic [1:0]  cause2;
  logic        fetch_valid2, trap_pulse2, halted2;

  int n_pass   = 0;
  int n_checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic        pulse;
    logic        fv;
    logic        halted;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pc_sequencer #(
    .DWIDTH(32), .RESET_VECTOR(32'h80), .TRAP_VECTOR(32'h100), .IALIGN(4)
  ) dut (
    .clk(clk), .reset(reset), .pc_en(pc_en), .pc_select(pc_select),
    .immgen_in(immgen_in), .rs1_in(rs1_in), .comparator(comparator),
    .trap_req(trap_req), .resume(resume), .fetch_ready(fetch_ready),
    .pc_value(pc_value), .pc_link(pc_link), .fetch_valid(fetch_valid),
    .epc(epc), .cause(cause), .trap_pulse(trap_pulse), .halted(halted)
  );

  pc_sequencer #(
    .DWIDTH(32), .RESET_VECTOR(32'h80), .TRAP_VECTOR(32'h100), .IALIGN(2)
  ) dut2 (
    .clk(clk), .reset(reset), .pc_en(pc_en), .pc_select(pc_select),
    .immgen_in(immgen_in), .rs1_in(rs1_in), .comparator(comparator),
    .trap_req(trap_req), .resume(resume), .fetch_ready(fetch_ready),
    .pc_value(pc_value2), .pc_link(pc_link2), .fetch_valid(fetch_valid2),
    .epc(epc2), .cause(cause2), .trap_pulse(trap_pulse2), .halted(halted2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive(input logic [2:0] sel, input logic [31:0] imm, input logic [31:0] rs1,
                       input logic cmp, input logic en, input logic rdy,
                       input logic trq, input logic res);
    pc_select   = sel;
    immgen_in   = imm;
    rs1_in      = rs1;
    comparator  = cmp;
    pc_en       = en;
    fetch_ready = rdy;
    trap_req    = trq;
    resume      = res;
  endtask

  task automatic expect_st(input string tag, input logic [31:0] pc, input logic [31:0] e_epc,
                           input logic [1:0] c, input logic pulse, input logic fv,
                           input logic h);
    exp_t e;
    e.tag = tag; e.pc = pc; e.epc = e_epc; e.cause = c;
    e.pulse = pulse; e.fv = fv; e.halted = h;
    sb.push_back(e);
  endtask

  task automatic compare_front();
    exp_t e;
    n_checks++;
    assert (sb.size() != 0) n_pass++;
    else $error("FAIL scoreboard_empty observed=%0d expected=1", sb.size());
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, ".pc"},     pc_value,    e.pc);
      chk({e.tag, ".link"},   pc_link,     e.pc + 32'd4);
      chk({e.tag, ".epc"},    epc,         e.epc);
      chk({e.tag, ".cause"},  cause,       e.cause);
      chk({e.tag, ".pulse"},  trap_pulse,  e.pulse);
      chk({e.tag, ".fv"},     fetch_valid, e.fv);
      chk({e.tag, ".halted"}, halted,      e.halted);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    compare_front();
  endtask

  initial begin
    reset = 1'b1;
    drive(NORMAL, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #3;
    expect_st("reset", 32'h80, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    compare_front();

    @(posedge clk);
    #1;
    reset = 1'b0;
    expect_st("boot", 32'h80, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    compare_front();

    expect_st("run_entry", 32'h80, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0);
    step();

    for (int i = 1; i <= 4; i++) begin
      drive(NORMAL, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      expect_st("normal", 32'h80 + 32'(4 * i), 32'h0, 2'd0, 1'b0, 1'b1, 1'b0);
      step();
    end

    // Branch taken / not taken from 0x100
    drive(JAL, 32'h70, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_st("jal_to_100", 32'h100, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0);
    step();
    drive(BRANCH, 32'hFFFF_FFF8, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_st("br_taken", 32'hF8, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0);
    step();
    drive(JAL, 32'h8, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_st("jal_fwd", 32'h100, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0);
    step();
    drive(BRANCH, 32'hFFFF_FFF8, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_st("br_not_taken", 32'h104, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0);
    step();
    drive(JAL, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_st("jal_back", 32'h100, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0);
    step();

    // Stall: nothing moves, and a trap_req during a stall is not taken
    for (int i = 0; i < 3; i++) begin
      drive(BRANCH, 32'hFFFF_FFF8, 32'h0, 1'b1, 1'b1, 1'b0, (i == 1), 1'b0);
      expect_st("stall", 32'h100, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0);
      step();
    end
    drive(BRANCH, 32'hFFFF_FFF8, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_st("stall_release", 32'hF8, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0);
    step();

    // JALR 0x203 -> 0x202: faults with IALIGN=4, legal with IALIGN=2
    drive(JALR, 32'h0, 32'h203, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_st("jalr_misalign", 32'h100, 32'hF8, 2'd1, 1'b1, 1'b1, 1'b0);
    step();
    chk("jalr_ialign2.pc",    pc_value2,   32'h202);
    chk("jalr_ialign2.cause", cause2,      32'd0);
    chk("jalr_ialign2.pulse", trap_pulse2, 32'd0);

    drive(NORMAL, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_st("pulse_single", 32'h100, 32'hF8, 2'd1, 1'b0, 1'b1, 1'b0);
    step();

    // JALR bit-0 clearing: 0x3F + 2 = 0x41 -> 0x40
    drive(JALR, 32'h2, 32'h3F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_st("jalr_clear_bit0", 32'h40, 32'hF8, 2'd1, 1'b0, 1'b1, 1'b0);
    step();

    // ECALL / MRET
    drive(ECALL, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_st("ecall", 32'h100, 32'h40, 2'd2, 1'b1, 1'b1, 1'b0);
    step();
    drive(MRET, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_st("mret", 32'h40, 32'h40, 2'd2, 1'b0, 1'b1, 1'b0);
    step();

    // External trap beats a misaligned JAL in the same commit
    drive(JAL, 32'h6, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    expect_st("ext_wins", 32'h100, 32'h40, 2'd3, 1'b1, 1'b1, 1'b0);
    step();
    // Back-to-back trap: misaligned JAL 0x100 -> 0x102
    drive(JAL, 32'h2, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_st("jal_misalign_b2b", 32'h100, 32'h100, 2'd1, 1'b1, 1'b1, 1'b0);
    step();
    drive(NORMAL, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_st("idle", 32'h100, 32'h100, 2'd1, 1'b0, 1'b1, 1'b0);
    step();

    // Wrap, halt, resume
    drive(JALR, 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_st("jalr_top", 32'hFFFF_FFFC, 32'h100, 2'd1, 1'b0, 1'b1, 1'b0);
    step();
    drive(NORMAL, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_st("wrap", 32'h0, 32'h100, 2'd1, 1'b0, 1'b1, 1'b0);
    step();
    drive(HALT, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_st("halt", 32'h4, 32'h100, 2'd1, 1'b0, 1'b0, 1'b1);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(NORMAL, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      expect_st("halt_ignore", 32'h4, 32'h100, 2'd1, 1'b0, 1'b0, 1'b1);
      step();
    end
    drive(NORMAL, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    expect_st("resume", 32'h4, 32'h100, 2'd1, 1'b0, 1'b1, 1'b0);
    step();
    drive(NORMAL, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_st("after_resume", 32'h8, 32'h100, 2'd1, 1'b0, 1'b1, 1'b0);
    step();
    drive(HALT, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_st("halt2", 32'hC, 32'h100, 2'd1, 1'b0, 1'b0, 1'b1);
    step();

    // Asynchronous reset mid-HALT, checked before any clock edge
    drive(NORMAL, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    #2;
    expect_st("reset_in_halt", 32'h80, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    compare_front();
    @(posedge clk);
    #1;
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
